calc_key_sequencer: RTL and testbench
=====================================

Name: calc_key_sequencer

Overview:
- Control stage directly upstream of the N-bit arithmetic unit (A/B/R registers plus adder/subtractor).
- Turns a stream of keypad key codes into operand values and the single-cycle LoadA, LoadB and LoadR strobes. Also produces the AddSub select and the unit clear.
- Handles one binary operation per calculation: A op B =. The arithmetic unit's Result and OVR are displayed downstream and are not consumed here.

Parameters:
- N, 8, operand width; must match the arithmetic unit width.

Ports:
- Clock  input  1  rising-edge system clock.
- ResetN  input  1  asynchronous active-low reset.
- KeyValid  input  1  one-cycle strobe; KeyCode is valid this cycle.
- KeyCode  input  4  0-9 digit, 10 '+', 11 '-', 12 '=', 13 'C'; 14-15 ignored.
- Operand  output  N  operand bus to the arithmetic unit data input.
- LoadA  output  1  one-cycle load strobe for register A.
- LoadB  output  1  one-cycle load strobe for register B.
- LoadR  output  1  one-cycle load strobe for the result register.
- AddSub  output  1  0 = add, 1 = subtract; held stable from operator acceptance to the next calculation.
- ClearAU  output  1  active-high clear to the arithmetic unit.
- Entry  output  N  current decimal entry value, for display.
- ShowResult  output  1  1 while the display should show the arithmetic unit result.
- Busy  output  1  1 in the LOAD_A, LOAD_B and COMPUTE states; keys arriving then are dropped.
- EntryErr  output  1  sticky; digit rejected because of width overflow.

Behaviour:
- Reset (ResetN=0, asynchronous):
  - State = ENTER_A.
  - Entry = 0, Operand = 0, AddSub = 0.
  - LoadA, LoadB, LoadR, ShowResult, Busy and EntryErr = 0.
  - ClearAU = 1 combinationally for the whole time ResetN is low.
- States: ENTER_A, LOAD_A, ENTER_B, LOAD_B, COMPUTE, RESULT. All outputs are registered except ClearAU's reset term.
- Digit d accepted in ENTER_A or ENTER_B:
  - Entry <= Entry*10 + d, computed at N+4 bits.
  - If the result exceeds 2^N-1: Entry is unchanged and EntryErr <= 1.
- Digit d accepted in RESULT:
  - Entry <= d, EntryErr <= 0, ShowResult <= 0, state -> ENTER_A.
  - Registers A/B/R are not cleared.
- '+' or '-' in ENTER_A:
  - Operand <= Entry; AddSub <= 0 for '+', 1 for '-'.
  - Entry <= 0, EntryErr <= 0, state -> LOAD_A.
- LOAD_A: LoadA=1 for exactly this cycle; state -> ENTER_B.
- '=' in ENTER_B:
  - Operand <= Entry, Entry <= 0, EntryErr <= 0, state -> LOAD_B.
- LOAD_B: LoadB=1 for this cycle; state -> COMPUTE.
- COMPUTE: LoadR=1 for this cycle (the adder settles during LOAD_B); state -> RESULT.
- RESULT: ShowResult=1.
- Latency from the accepting key cycle:
  - LoadA at cycle +1.
  - LoadB at cycle +1.
  - LoadR at cycle +2.
  - ShowResult at cycle +3.
- Operand holds its value after every load strobe until the next operator or '=' acceptance.
- Ignored keys (no state change):
  - '=' in ENTER_A.
  - Operator in ENTER_B or RESULT.
  - Codes 14-15.
  - Any key while Busy=1.
- 'C' (code 13) in any state, including Busy states:
  - ClearAU=1 for one cycle.
  - State -> ENTER_A; Entry, Operand, AddSub, EntryErr and ShowResult cleared.
  - Any pending load strobe is suppressed.
  - 'C' takes priority over all other events in the same cycle.
- At most one load strobe is high in any cycle.
- ResetN asserted mid-sequence aborts immediately. No strobe is issued after ResetN releases until new keys arrive.

Test Plan:
- Reset, then keys 1,2,'+',3,'=' -> LoadA pulse with Operand=12; LoadB pulse with Operand=3; LoadR one cycle after LoadB; ShowResult=1 in the cycle after LoadR; AddSub=0 throughout.
- Keys 5,'-',7,'=' -> AddSub=1 from the cycle after '-' is accepted through RESULT; Operand=5 at LoadA, Operand=7 at LoadB.
- N=8, keys 2,5,5 then 6 -> Entry=255 after the third digit; Entry stays 255 and EntryErr=1 after 6; next '+' clears EntryErr and LoadA carries 255.
- '+' key presented on the cycle after LoadA's triggering key (Busy=1), and '=' in ENTER_A -> both dropped; no extra strobes; state sequence unchanged.
- 'C' asserted in the cycle LoadB would fire -> no LoadB or LoadR; ClearAU=1 for one cycle; Entry=0; state ENTER_A.
- In RESULT press 9 -> ShowResult=0, Entry=9, state ENTER_A. Then pull ResetN low asynchronously -> all outputs go to their reset values without waiting for a clock edge.

Source files
------------

// File: rtl/calc_key_sequencer.sv
// Keypad-to-arithmetic-unit sequencer: accumulates decimal entries and issues
// the A/B/R load strobes for a single "A op B =" calculation.
module calc_key_sequencer #(
  parameter int N = 8
) (
  input  logic         Clock,
  input  logic         ResetN,
  input  logic         KeyValid,
  input  logic [3:0]   KeyCode,
  output logic [N-1:0] Operand,
  output logic         LoadA,
  output logic         LoadB,
  output logic         LoadR,
  output logic         AddSub,
  output logic         ClearAU,
  output logic [N-1:0] Entry,
  output logic         ShowResult,
  output logic         Busy,
  output logic         EntryErr
);

  localparam logic [3:0] K_ADD = 4'd10;
  localparam logic [3:0] K_SUB = 4'd11;
  localparam logic [3:0] K_EQ  = 4'd12;
  localparam logic [3:0] K_CLR = 4'd13;

  typedef enum logic [2:0] {
    ENTER_A, LOAD_A, ENTER_B, LOAD_B, COMPUTE, RESULT
  } state_t;

  state_t     state;
  logic       clr_q;
  logic       is_digit;
  logic       is_clr;
  logic [N+3:0] nxt_entry;
  logic       ovf;

  assign is_digit  = KeyValid && (KeyCode <= 4'd9);
  assign is_clr    = KeyValid && (KeyCode == K_CLR);
  // Four guard bits hold the full Entry*10+d so overflow is exact.
  assign nxt_entry = ({4'b0, Entry} * (N+4)'(10)) + (N+4)'(KeyCode);
  assign ovf       = |nxt_entry[N+3:N];

  // The reset term reaches the arithmetic unit without waiting for a clock.
  assign ClearAU = ~ResetN | clr_q;

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state      <= ENTER_A;
      Entry      <= '0;
      Operand    <= '0;
      AddSub     <= 1'b0;
      LoadA      <= 1'b0;
      LoadB      <= 1'b0;
      LoadR      <= 1'b0;
      ShowResult <= 1'b0;
      Busy       <= 1'b0;
      EntryErr   <= 1'b0;
      clr_q      <= 1'b0;
    end else begin
      LoadA <= 1'b0;
      LoadB <= 1'b0;
      LoadR <= 1'b0;
      clr_q <= 1'b0;
      if (is_clr) begin
        // Leaving LOAD_B/COMPUTE here drops any strobe not yet issued.
        state      <= ENTER_A;
        Entry      <= '0;
        Operand    <= '0;
        AddSub     <= 1'b0;
        EntryErr   <= 1'b0;
        ShowResult <= 1'b0;
        Busy       <= 1'b0;
        clr_q      <= 1'b1;
      end else begin
        case (state)
          ENTER_A: begin
            if (is_digit) begin
              if (ovf) EntryErr <= 1'b1;
              else     Entry    <= nxt_entry[N-1:0];
            end else if (KeyValid && (KeyCode == K_ADD || KeyCode == K_SUB)) begin
              Operand  <= Entry;
              AddSub   <= (KeyCode == K_SUB);
              Entry    <= '0;
              EntryErr <= 1'b0;
              LoadA    <= 1'b1;
              Busy     <= 1'b1;
              state    <= LOAD_A;
            end
          end
          LOAD_A: begin
            Busy  <= 1'b0;
            state <= ENTER_B;
          end
          ENTER_B: begin
            if (is_digit) begin
              if (ovf) EntryErr <= 1'b1;
              else     Entry    <= nxt_entry[N-1:0];
            end else if (KeyValid && KeyCode == K_EQ) begin
              Operand  <= Entry;
              Entry    <= '0;
              EntryErr <= 1'b0;
              LoadB    <= 1'b1;
              Busy     <= 1'b1;
              state    <= LOAD_B;
            end
          end
          LOAD_B: begin
            LoadR <= 1'b1;
            state <= COMPUTE;
          end
          COMPUTE: begin
            Busy       <= 1'b0;
            ShowResult <= 1'b1;
            state      <= RESULT;
          end
          RESULT: begin
            if (is_digit) begin
              Entry      <= N'(KeyCode);
              EntryErr   <= 1'b0;
              ShowResult <= 1'b0;
              state      <= ENTER_A;
            end
          end
          default: state <= ENTER_A;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_calc_key_sequencer.sv
// Directed bench for calc_key_sequencer: one key slot per cycle, outputs
// compared against hand-computed expectations after each clock edge.
module tb_calc_key_sequencer;

  localparam int N = 8;

  logic         Clock = 1'b0;
  logic         ResetN;
  logic         KeyValid;
  logic [3:0]   KeyCode;
  logic [N-1:0] Operand;
  logic         LoadA, LoadB, LoadR, AddSub, ClearAU;
  logic [N-1:0] Entry;
  logic         ShowResult, Busy, EntryErr;

  calc_key_sequencer #(.N(N)) dut (
    .Clock(Clock), .ResetN(ResetN), .KeyValid(KeyValid), .KeyCode(KeyCode),
    .Operand(Operand), .LoadA(LoadA), .LoadB(LoadB), .LoadR(LoadR),
    .AddSub(AddSub), .ClearAU(ClearAU), .Entry(Entry),
    .ShowResult(ShowResult), .Busy(Busy), .EntryErr(EntryErr)
  );

  always #5 Clock = ~Clock;

  typedef struct packed {
    logic [N-1:0] entry;
    logic [N-1:0] operand;
    logic la, lb, lr, as, cl, sh, bz, er;
  } out_t;

  typedef struct packed {
    logic       valid;
    logic [3:0] code;
    out_t       exp;
  } vec_t;

  vec_t vecs[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  function automatic out_t mk(input logic [N-1:0] e, input logic [N-1:0] op,
                              input logic la, lb, lr, as, cl, sh, bz, er);
    out_t o;
    o = '{e, op, la, lb, lr, as, cl, sh, bz, er};
    return o;
  endfunction

  function automatic out_t actual();
    out_t o;
    o = '{Entry, Operand, LoadA, LoadB, LoadR, AddSub, ClearAU, ShowResult, Busy, EntryErr};
    return o;
  endfunction

  task automatic check(input string name, input out_t exp);
    out_t a;
    a = actual();
    n_chk++;
    if (a === exp) n_pass++;
    else $display("FAIL %s: got entry=%0d op=%0d la/lb/lr/as/cl/sh/bz/er=%b%b%b%b%b%b%b%b, want entry=%0d op=%0d la/lb/lr/as/cl/sh/bz/er=%b%b%b%b%b%b%b%b",
                  name, a.entry, a.operand, a.la, a.lb, a.lr, a.as, a.cl, a.sh, a.bz, a.er,
                  exp.entry, exp.operand, exp.la, exp.lb, exp.lr, exp.as, exp.cl, exp.sh, exp.bz, exp.er);
  endtask

  // Drive one key slot at a falling edge, check after the next rising edge.
  task automatic step(input string name, input logic v, input logic [3:0] c, input out_t exp);
    KeyValid = v;
    KeyCode  = c;
    @(negedge Clock);
    KeyValid = 1'b0;
    KeyCode  = 4'd0;
    check(name, exp);
  endtask

  task automatic add(input logic v, input logic [3:0] c, input out_t exp);
    vec_t t;
    t = '{v, c, exp};
    vecs.push_back(t);
  endtask

  initial begin
    //       v  code  entry op   la lb lr as cl sh bz er
    add(1, 4'd1,  mk(  1,   0, 0, 0, 0, 0, 0, 0, 0, 0));
    add(1, 4'd2,  mk( 12,   0, 0, 0, 0, 0, 0, 0, 0, 0));
    add(1, 4'd10, mk(  0,  12, 1, 0, 0, 0, 0, 0, 1, 0));
    add(1, 4'd10, mk(  0,  12, 0, 0, 0, 0, 0, 0, 0, 0)); // '+' while busy
    add(1, 4'd3,  mk(  3,  12, 0, 0, 0, 0, 0, 0, 0, 0));
    add(1, 4'd12, mk(  0,   3, 0, 1, 0, 0, 0, 0, 1, 0));
    add(1, 4'd12, mk(  0,   3, 0, 0, 1, 0, 0, 0, 1, 0)); // '=' while busy
    add(1, 4'd9,  mk(  0,   3, 0, 0, 0, 0, 0, 1, 0, 0)); // digit while busy
    add(0, 4'd0,  mk(  0,   3, 0, 0, 0, 0, 0, 1, 0, 0));
    add(1, 4'd5,  mk(  5,   3, 0, 0, 0, 0, 0, 0, 0, 0));
    add(1, 4'd12, mk(  5,   3, 0, 0, 0, 0, 0, 0, 0, 0)); // '=' in ENTER_A
    add(1, 4'd11, mk(  0,   5, 1, 0, 0, 1, 0, 0, 1, 0));
    add(0, 4'd0,  mk(  0,   5, 0, 0, 0, 1, 0, 0, 0, 0));
    add(1, 4'd7,  mk(  7,   5, 0, 0, 0, 1, 0, 0, 0, 0));
    add(1, 4'd14, mk(  7,   5, 0, 0, 0, 1, 0, 0, 0, 0)); // code 14 ignored
    add(1, 4'd12, mk(  0,   7, 0, 1, 0, 1, 0, 0, 1, 0));
    add(0, 4'd0,  mk(  0,   7, 0, 0, 1, 1, 0, 0, 1, 0));
    add(0, 4'd0,  mk(  0,   7, 0, 0, 0, 1, 0, 1, 0, 0));
    add(1, 4'd10, mk(  0,   7, 0, 0, 0, 1, 0, 1, 0, 0)); // operator in RESULT
    add(1, 4'd2,  mk(  2,   7, 0, 0, 0, 1, 0, 0, 0, 0));
    add(1, 4'd5,  mk( 25,   7, 0, 0, 0, 1, 0, 0, 0, 0));
    add(1, 4'd5,  mk(255,   7, 0, 0, 0, 1, 0, 0, 0, 0));
    add(1, 4'd6,  mk(255,   7, 0, 0, 0, 1, 0, 0, 0, 1)); // width overflow
    add(1, 4'd10, mk(  0, 255, 1, 0, 0, 0, 0, 0, 1, 0));
    add(0, 4'd0,  mk(  0, 255, 0, 0, 0, 0, 0, 0, 0, 0));

    ResetN   = 1'b0;
    KeyValid = 1'b0;
    KeyCode  = 4'd0;
    #1 check("reset_state", mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    @(negedge Clock);
    @(negedge Clock);
    ResetN = 1'b1;
    @(negedge Clock);
    check("post_reset_idle", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    foreach (vecs[i])
      step($sformatf("vec%0d", i), vecs[i].valid, vecs[i].code, vecs[i].exp);

    // 'C' arrives while LoadB is up: LoadR must never follow.
    step("clr_b_digit", 1, 4'd4,  mk(4, 255, 0, 0, 0, 0, 0, 0, 0, 0));
    step("clr_b_eq",    1, 4'd12, mk(0,   4, 0, 1, 0, 0, 0, 0, 1, 0));
    step("clr_key",     1, 4'd13, mk(0,   0, 0, 0, 0, 0, 1, 0, 0, 0));
    step("clr_after1",  0, 4'd0,  mk(0,   0, 0, 0, 0, 0, 0, 0, 0, 0));
    step("clr_after2",  0, 4'd0,  mk(0,   0, 0, 0, 0, 0, 0, 0, 0, 0));
    step("clr_enter_a", 1, 4'd8,  mk(8,   0, 0, 0, 0, 0, 0, 0, 0, 0));
    step("clr_load_a",  1, 4'd10, mk(0,   8, 1, 0, 0, 0, 0, 0, 1, 0));
    step("r_idle",      0, 4'd0,  mk(0,   8, 0, 0, 0, 0, 0, 0, 0, 0));
    step("r_digit",     1, 4'd1,  mk(1,   8, 0, 0, 0, 0, 0, 0, 0, 0));
    step("r_eq",        1, 4'd12, mk(0,   1, 0, 1, 0, 0, 0, 0, 1, 0));
    step("r_compute",   0, 4'd0,  mk(0,   1, 0, 0, 1, 0, 0, 0, 1, 0));
    step("r_result",    0, 4'd0,  mk(0,   1, 0, 0, 0, 0, 0, 1, 0, 0));
    step("r_new_digit", 1, 4'd9,  mk(9,   1, 0, 0, 0, 0, 0, 0, 0, 0));
    step("r_back_in_a", 1, 4'd11, mk(0,   9, 1, 0, 0, 1, 0, 0, 1, 0));

    // Asynchronous reset mid-sequence, away from any clock edge.
    #2 ResetN = 1'b0;
    #1 check("async_reset", mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    @(negedge Clock);
    ResetN = 1'b1;
    @(negedge Clock);
    check("rel_idle1", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge Clock);
    check("rel_idle2", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
